// File: rtl/adaptive_colour_quantiser.sv
// Adaptive per-channel colour binariser: one bit per channel, set when the
// channel exceeds a clamped sliding-window average, a fixed value, or both.
//
// Ports:
//   clk_in, rst_n_in   clock (rising edge), async active-low reset
//   pix_valid_in       pixel accept strobe (one pixel per high cycle)
//   sof_in             start of frame, qualified by pix_valid_in
//   pix_in             NUM_CH channels of COLOUR_DEPTH bits, channel 0 at LSBs
//   mode_in            0/3 adaptive, 1 fixed, 2 adaptive + offset
//   fixed_thres_in     fixed threshold (mode 1 and warm-up) or offset (mode 2)
//   pix_valid_out      result strobe, one cycle after the accepted pixel
//   sof_out            sof_in of the last accepted pixel
//   compressed_out     bit c = channel c above its threshold
//   warm_out           high while the window is still filling
module adaptive_colour_quantiser #(
  parameter int NUM_CH         = 3,
  parameter int COLOUR_DEPTH   = 8,
  parameter int WINDOW         = 1024,
  parameter int MIN_THRES      = 1 << ($clog2(WINDOW) - 4),
  parameter int MAX_THRES      = 1 << ($clog2(WINDOW) - 1),
  parameter bit RESTART_ON_SOF = 1'b1
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           pix_valid_in,
  input  logic                           sof_in,
  input  logic [NUM_CH*COLOUR_DEPTH-1:0] pix_in,
  input  logic [1:0]                     mode_in,
  input  logic [COLOUR_DEPTH-1:0]        fixed_thres_in,
  output logic                           pix_valid_out,
  output logic                           sof_out,
  output logic [NUM_CH-1:0]              compressed_out,
  output logic                           warm_out
);

  localparam int CW = COLOUR_DEPTH;
  localparam int WB = $clog2(WINDOW);
  localparam int SW = CW + WB;
  // One spare bit so clamp bounds and offset sums never wrap.
  localparam int TW = SW + 1;
  localparam int PW = NUM_CH * CW;

  localparam logic [TW-1:0] MIN_T = TW'(MIN_THRES);
  localparam logic [TW-1:0] MAX_T = TW'(MAX_THRES);
  localparam logic [TW-1:0] SAT_T = TW'((1 << CW) - 1);
  localparam logic [WB:0]   FILL_LAST = (WB + 1)'(WINDOW - 1);

  typedef enum logic {
    WARMUP = 1'b0,
    TRACK  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [WB:0]   fill_q, fill_d;
  logic [WB-1:0] ptr_q, ptr_d;
  logic [WB-1:0] wr_addr;

  logic [NUM_CH-1:0][SW-1:0] sum_q, sum_d;

  logic [PW-1:0] win_q [WINDOW];
  logic [PW-1:0] old_pix;

  logic [NUM_CH-1:0][CW-1:0] pix_c;
  logic [NUM_CH-1:0][CW-1:0] old_c;

  logic [NUM_CH-1:0][TW-1:0] avg;
  logic [NUM_CH-1:0][TW-1:0] clamped;
  logic [NUM_CH-1:0][TW-1:0] offs;
  logic [NUM_CH-1:0][TW-1:0] thres;
  logic [NUM_CH-1:0]         hit_d;

  logic restart;
  logic use_fix;
  logic use_off;

  assign restart = pix_valid_in & sof_in & RESTART_ON_SOF;

  // Restart lands the pixel in slot 0 so the new window starts clean.
  assign wr_addr = restart ? '0 : ptr_q;
  assign old_pix = win_q[ptr_q];

  always_comb begin
    pix_c = '0;
    old_c = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pix_c[c] = pix_in[c*CW +: CW];
      old_c[c] = old_pix[c*CW +: CW];
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= WARMUP;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (pix_valid_in) begin
      if (restart) begin
        state_d = WARMUP;
      end else if (state_q == WARMUP &&
                   fill_q == FILL_LAST) begin
        state_d = TRACK;
      end
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    warm_out = (state_q == WARMUP);
  end

  // ---------------- window bookkeeping ----------------
  always_comb begin
    fill_d = fill_q;
    ptr_d  = ptr_q;
    sum_d  = sum_q;
    if (pix_valid_in) begin
      if (restart) begin
        fill_d = (WB + 1)'(1);
        ptr_d  = WB'(1);
        for (int c = 0; c < NUM_CH; c++) begin
          sum_d[c] = SW'(pix_c[c]);
        end
      end else if (state_q == WARMUP) begin
        fill_d = fill_q + (WB + 1)'(1);
        ptr_d  = ptr_q + WB'(1);
        for (int c = 0; c < NUM_CH; c++) begin
          sum_d[c] = sum_q[c] + SW'(pix_c[c]);
        end
      end else begin
        ptr_d = ptr_q + WB'(1);
        // The slot being overwritten is the oldest sample in the window.
        for (int c = 0; c < NUM_CH; c++) begin
          sum_d[c] = sum_q[c] + SW'(pix_c[c])
                   - SW'(old_c[c]);
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fill_q <= '0;
      ptr_q  <= '0;
      sum_q  <= '0;
    end else begin
      fill_q <= fill_d;
      ptr_q  <= ptr_d;
      sum_q  <= sum_d;
    end
  end

  // Window storage carries no reset; stale slots are never summed
  // because WARMUP only adds until the window is full again.
  always_ff @(posedge clk_in) begin
    if (pix_valid_in) begin
      win_q[wr_addr] <= pix_in;
    end
  end

  // ---------------- threshold selection ----------------
  assign use_fix = restart | (state_q == WARMUP)
                 | (mode_in == 2'd1);
  assign use_off = ~use_fix & (mode_in == 2'd2);

  always_comb begin
    avg     = '0;
    clamped = '0;
    offs    = '0;
    thres   = '0;
    hit_d   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      avg[c] = TW'(sum_q[c] >> WB);
      clamped[c] = avg[c];
      if (clamped[c] < MIN_T) begin
        clamped[c] = MIN_T;
      end
      if (clamped[c] > MAX_T) begin
        clamped[c] = MAX_T;
      end
      offs[c] = clamped[c] + TW'(fixed_thres_in);
      if (offs[c] > SAT_T) begin
        offs[c] = SAT_T;
      end
      unique case (1'b1)
        use_fix: thres[c] = TW'(fixed_thres_in);
        use_off: thres[c] = offs[c];
        default: thres[c] = clamped[c];
      endcase
      hit_d[c] = TW'(pix_c[c]) > thres[c];
    end
  end

  // ---------------- result registers ----------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pix_valid_out  <= 1'b0;
      sof_out        <= 1'b0;
      compressed_out <= '0;
    end else begin
      pix_valid_out <= pix_valid_in;
      if (pix_valid_in) begin
        sof_out        <= sof_in;
        compressed_out <= hit_d;
      end
    end
  end

endmodule

// File: tb/tb_adaptive_colour_quantiser.sv
// Testbench for adaptive_colour_quantiser: directed scenarios plus a
// randomized run against a queue-based window-average reference model.
module tb_adaptive_colour_quantiser;

  localparam int W = 16;
  localparam int MINT = 8;
  localparam int MAXT = 128;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        pix_valid_in = 1'b0;
  logic        sof_in = 1'b0;
  logic [23:0] pix_in = '0;
  logic [1:0]  mode_in = '0;
  logic [7:0]  fixed_thres_in = '0;
  logic        pix_valid_out;
  logic        sof_out;
  logic [2:0]  compressed_out;
  logic        warm_out;

  always #5 clk_in = ~clk_in;

  adaptive_colour_quantiser #(
    .NUM_CH(3),
    .COLOUR_DEPTH(8),
    .WINDOW(W),
    .MIN_THRES(MINT),
    .MAX_THRES(MAXT),
    .RESTART_ON_SOF(1'b1)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .pix_valid_in(pix_valid_in),
    .sof_in(sof_in),
    .pix_in(pix_in),
    .mode_in(mode_in),
    .fixed_thres_in(fixed_thres_in),
    .pix_valid_out(pix_valid_out),
    .sof_out(sof_out),
    .compressed_out(compressed_out),
    .warm_out(warm_out)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: pixels since the last restart, newest at the back,
  // trimmed to the last W entries.
  int         mq [3][$];
  logic [2:0] exp_bits;
  logic       exp_warm;

  function automatic int ref_thres(int c, int mode, int fx);
    int s, avg, cl;
    if (mq[c].size() < W) return fx;
    s = 0;
    for (int i = 0; i < mq[c].size(); i++) s += mq[c][i];
    avg = s / W;
    cl = (avg < MINT) ? MINT : avg;
    if (cl > MAXT) cl = MAXT;
    if (mode == 1) return fx;
    if (mode == 2) return (cl + fx > 255) ? 255 : cl + fx;
    return cl;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 3; c++) mq[c].delete();
  endtask

  task automatic send(input int r, input int g, input int b,
                      input bit sof, input int mode, input int fx);
    int px[3];
    px[0] = r;
    px[1] = g;
    px[2] = b;
    if (sof) model_clear();
    for (int c = 0; c < 3; c++) begin
      exp_bits[c] = (px[c] > ref_thres(c, mode, fx));
      mq[c].push_back(px[c]);
      if (mq[c].size() > W) void'(mq[c].pop_front());
    end
    exp_warm = (mq[0].size() < W);
    pix_in = {8'(b), 8'(g), 8'(r)};
    sof_in = sof;
    mode_in = 2'(mode);
    fixed_thres_in = 8'(fx);
    pix_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    pix_valid_in = 1'b0;
    sof_in = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (pix_valid_out !== 1'b0 || sof_out !== 1'b0 ||
        compressed_out !== 3'b000 || warm_out !== 1'b1) begin
      errors++;
      $display("FAIL reset: got v=%b s=%b c=%b w=%b want 0 0 000 1",
               pix_valid_out, sof_out, compressed_out, warm_out);
    end
    #20;
    rst_n_in = 1'b1;
    model_clear();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_warmup();
    for (int i = 0; i < 15; i++) begin
      send(50, 50, 50, 0, 0, 100);
      checks++;
      if (pix_valid_out !== 1'b1 || compressed_out !== 3'b000 ||
          warm_out !== 1'b1) begin
        errors++;
        $display("FAIL warmup_%0d: got v=%b c=%b w=%b want 1 000 1",
                 i, pix_valid_out, compressed_out, warm_out);
      end
    end
    send(200, 200, 200, 0, 0, 100);
    checks++;
    if (compressed_out !== 3'b111 || warm_out !== 1'b0) begin
      errors++;
      $display("FAIL warmup_last: got c=%b w=%b want 111 0",
               compressed_out, warm_out);
    end
    send(60, 60, 60, 0, 0, 100);
    checks++;
    if (compressed_out !== 3'b111) begin
      errors++;
      $display("FAIL track_60: got %b want 111", compressed_out);
    end
    send(59, 59, 59, 0, 0, 100);
    checks++;
    if (compressed_out !== 3'b000) begin
      errors++;
      $display("FAIL track_59: got %b want 000", compressed_out);
    end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < W; i++) send(255, 255, 255, 0, 0, 100);
    send(129, 129, 129, 0, 0, 100);
    checks++;
    if (compressed_out !== 3'b111) begin
      errors++;
      $display("FAIL clamp_hi_129: got %b want 111", compressed_out);
    end
    send(128, 128, 128, 0, 0, 100);
    checks++;
    if (compressed_out !== 3'b000) begin
      errors++;
      $display("FAIL clamp_hi_128: got %b want 000", compressed_out);
    end
    for (int i = 0; i < W; i++) send(0, 0, 0, 0, 0, 100);
    send(9, 9, 9, 0, 0, 100);
    checks++;
    if (compressed_out !== 3'b111) begin
      errors++;
      $display("FAIL clamp_lo_9: got %b want 111", compressed_out);
    end
    send(8, 8, 8, 0, 0, 100);
    checks++;
    if (compressed_out !== 3'b000) begin
      errors++;
      $display("FAIL clamp_lo_8: got %b want 000", compressed_out);
    end
  endtask

  task automatic test_gaps();
    int fr[W], fg[W], fb[W];
    int pr[10], pg[10], pb[10];
    logic [2:0] res_gap[10];
    logic [2:0] hold_c;
    logic       hold_s;
    for (int i = 0; i < W; i++) begin
      fr[i] = $urandom_range(0, 255);
      fg[i] = $urandom_range(0, 255);
      fb[i] = $urandom_range(0, 255);
    end
    for (int i = 0; i < 10; i++) begin
      pr[i] = $urandom_range(0, 255);
      pg[i] = $urandom_range(0, 255);
      pb[i] = $urandom_range(0, 255);
    end
    for (int i = 0; i < W; i++)
      send(fr[i], fg[i], fb[i], i == 0, 0, 100);
    for (int i = 0; i < 10; i++) begin
      send(pr[i], pg[i], pb[i], 0, 0, 100);
      checks++;
      if (compressed_out !== exp_bits) begin
        errors++;
        $display("FAIL gap_pix_%0d: got %b want %b",
                 i, compressed_out, exp_bits);
      end
      res_gap[i] = compressed_out;
      hold_c = compressed_out;
      hold_s = sof_out;
      repeat (5) begin
        @(posedge clk_in);
        #1;
        checks++;
        if (pix_valid_out !== 1'b0 || compressed_out !== hold_c ||
            sof_out !== hold_s) begin
          errors++;
          $display("FAIL gap_idle_%0d: got v=%b c=%b s=%b want 0 %b %b",
                   i, pix_valid_out, compressed_out, sof_out,
                   hold_c, hold_s);
        end
      end
    end
    for (int i = 0; i < W; i++)
      send(fr[i], fg[i], fb[i], i == 0, 0, 100);
    for (int i = 0; i < 10; i++) begin
      send(pr[i], pg[i], pb[i], 0, 0, 100);
      checks++;
      if (compressed_out !== res_gap[i]) begin
        errors++;
        $display("FAIL gap_vs_nogap_%0d: got %b want %b",
                 i, compressed_out, res_gap[i]);
      end
    end
  endtask

  task automatic test_restart();
    for (int i = 0; i < W; i++) send(200, 200, 200, 0, 0, 100);
    send(150, 150, 150, 1, 0, 100);
    checks++;
    if (compressed_out !== 3'b111 || sof_out !== 1'b1 ||
        warm_out !== 1'b1) begin
      errors++;
      $display("FAIL restart_sof: got c=%b s=%b w=%b want 111 1 1",
               compressed_out, sof_out, warm_out);
    end
    for (int i = 0; i < W - 1; i++) begin
      send(120, 120, 120, 0, 0, 100);
      checks++;
      if (compressed_out !== 3'b111 || sof_out !== 1'b0 ||
          warm_out !== (i < W - 2)) begin
        errors++;
        $display("FAIL restart_warm_%0d: got c=%b s=%b w=%b want 111 0 %b",
                 i, compressed_out, sof_out, warm_out, i < W - 2);
      end
    end
    send(122, 122, 122, 0, 0, 100);
    checks++;
    if (compressed_out !== 3'b111) begin
      errors++;
      $display("FAIL restart_avg_122: got %b want 111", compressed_out);
    end
    send(120, 120, 120, 0, 0, 100);
    checks++;
    if (compressed_out !== 3'b000) begin
      errors++;
      $display("FAIL restart_avg_120: got %b want 000", compressed_out);
    end
  endtask

  task automatic test_mode2();
    send(50, 50, 50, 1, 0, 100);
    for (int i = 0; i < W - 2; i++) send(50, 50, 50, 0, 0, 100);
    send(200, 200, 200, 0, 0, 100);
    send(80, 80, 80, 0, 2, 20);
    checks++;
    if (compressed_out !== 3'b111) begin
      errors++;
      $display("FAIL mode2_80: got %b want 111", compressed_out);
    end
    send(79, 79, 79, 0, 2, 20);
    checks++;
    if (compressed_out !== 3'b000) begin
      errors++;
      $display("FAIL mode2_79: got %b want 000", compressed_out);
    end
    send(255, 255, 255, 1, 0, 100);
    for (int i = 0; i < W - 1; i++) send(255, 255, 255, 0, 0, 100);
    send(255, 255, 255, 0, 2, 200);
    checks++;
    if (compressed_out !== 3'b000) begin
      errors++;
      $display("FAIL mode2_sat_255: got %b want 000", compressed_out);
    end
  endtask

  task automatic test_mixed_and_reset();
    send(200, 10, 100, 0, 1, 100);
    checks++;
    if (compressed_out !== 3'b001) begin
      errors++;
      $display("FAIL mixed_channels: got %b want 001", compressed_out);
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    checks++;
    if (pix_valid_out !== 1'b0 || sof_out !== 1'b0 ||
        compressed_out !== 3'b000 || warm_out !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got v=%b s=%b c=%b w=%b want 0 0 000 1",
               pix_valid_out, sof_out, compressed_out, warm_out);
    end
    #10;
    rst_n_in = 1'b1;
    model_clear();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit s;
      int m, fx, r, g, b, gap;
      s = ($urandom_range(0, 39) == 0);
      m = $urandom_range(0, 3);
      fx = $urandom_range(0, 255);
      r = $urandom_range(0, 255);
      g = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      send(r, g, b, s, m, fx);
      checks++;
      if (pix_valid_out !== 1'b1 || compressed_out !== exp_bits ||
          sof_out !== s || warm_out !== exp_warm) begin
        errors++;
        $display("FAIL random_%0d: got v=%b c=%b s=%b w=%b want 1 %b %b %b",
                 i, pix_valid_out, compressed_out, sof_out, warm_out,
                 exp_bits, s, exp_warm);
      end
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk_in);
        #1;
        checks++;
        if (pix_valid_out !== 1'b0 || compressed_out !== exp_bits) begin
          errors++;
          $display("FAIL random_gap_%0d: got v=%b c=%b want 0 %b",
                   i, pix_valid_out, compressed_out, exp_bits);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_clamp();
    test_gaps();
    test_restart();
    test_mode2();
    test_mixed_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
